// File: rtl/hex_display_scanner.sv
// hex_display_scanner: scanned, double-buffered hex display driver with per-digit blanking; define HEX_SCAN_BLINK_EN for per-digit blinking
module hex_display_scanner #(
  parameter int DIGITS = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  pending,
  output logic                  frame_done
`ifdef HEX_SCAN_BLINK_EN
  ,
  input  logic [DIGITS-1:0]     blink_mask
`endif
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW != 0 ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] EN_OFF = SEG_ACTIVE_LOW != 0 ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  // active-low glyphs, nibble k at bits [8k+7:8k], DP bit kept dark
  localparam logic [127:0] HEX = 128'h8E86A1C6_83889080_F8829299_B0A4F9C0;
  typedef enum logic {BLANK, DRIVE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [4*DIGITS-1:0] sh_val, act_val;
  logic [DIGITS-1:0] sh_blank, act_blank, onehot, en_nx;
  logic slot_end, boundary, dark, blink_dark;
  logic [3:0] nib;
  logic [7:0] seg_al, seg_nx;
`ifdef HEX_SCAN_BLINK_EN
  logic [DIGITS-1:0] sh_blink, act_blink;
  logic [4:0] fcnt;
  logic phase;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sh_blink <= '0;
      act_blink <= '0;
      fcnt <= '0;
      phase <= 1'b0;
    end else begin
      if (load) sh_blink <= blink_mask;
      if (boundary && (pending || load)) act_blink <= load ? blink_mask : sh_blink;
      if (boundary) fcnt <= fcnt + 5'd1;
      if (boundary && fcnt == 5'd31) phase <= ~phase;
    end
  end
  assign blink_dark = phase & act_blink[idx];
`else
  assign blink_dark = 1'b0;
`endif
  always_comb begin
    slot_end = cnt == LAST_CNT;
    boundary = slot_end && idx == LAST_IDX;
    state_nx = slot_end ? BLANK : DRIVE;
    nib = act_val[{idx, 2'b00} +: 4];
    dark = state == BLANK || act_blank[idx] || blink_dark;
    seg_al = dark ? 8'hFF : HEX[{nib, 3'b000} +: 8] & {~dp_mask[idx], 7'h7F};
    seg_nx = SEG_ACTIVE_LOW != 0 ? seg_al : ~seg_al;
    onehot = DIGITS'(1) << idx;
    en_nx = state == BLANK ? EN_OFF : (SEG_ACTIVE_LOW != 0 ? ~onehot : onehot);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= BLANK;
    else state <= state_nx;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
      sh_val <= '0;
      sh_blank <= '0;
      act_val <= '0;
      act_blank <= '0;
      pending <= 1'b0;
      frame_done <= 1'b0;
      seg_out <= SEG_OFF;
      digit_en <= EN_OFF;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) idx <= idx == LAST_IDX ? '0 : idx + IW'(1);
      if (load) begin
        sh_val <= value;
        sh_blank <= blank_mask;
      end
      // a load landing on the boundary bypasses the shadow so it is shown this frame
      if (boundary && (pending || load)) begin
        act_val <= load ? value : sh_val;
        act_blank <= load ? blank_mask : sh_blank;
      end
      pending <= !boundary && (pending || load);
      frame_done <= boundary;
      seg_out <= seg_nx;
      digit_en <= en_nx;
    end
  end
endmodule

// File: doc/hex_display_scanner.md
# hex_display_scanner

Parametrised, time-multiplexed hex display driver for the FPGA board interface layer. Takes a packed nibble vector from the datapath (TM state, tape address, counters) and drives a shared segment bus plus one-hot digit enables, scanning one digit at a time. It replaces per-digit combinational hex decoders with a double-buffered, tear-free, scanned display that has per-digit blanking.

## Interface
Parameters:
- DIGITS, 8, number of digits scanned; legal 1..16
- REFRESH_DIV, 50000, clock cycles per digit slot; legal >= 2
- SEG_ACTIVE_LOW, 1, 1 = segments/enables active-low; 0 = both outputs inverted

Ports:
- clock  in  1  system clock; all state rises on posedge
- reset  in  1  asynchronous, active-low reset
- load  in  1  one-cycle strobe; capture value and blank_mask into shadow
- value  in  4*DIGITS  packed nibbles; digit k = value[4k+3:4k], digit 0 rightmost
- blank_mask  in  DIGITS  1 = digit k forced dark; captured with load
- dp_mask  in  DIGITS  decimal point per digit, sampled live (not buffered)
- seg_out  out  8  registered segments, bit 7 = DP, bits 6:0 = g..a
- digit_en  out  DIGITS  registered one-hot digit enable
- pending  out  1  shadow holds data not yet applied to the display
- frame_done  out  1  one-cycle pulse at end of each full scan

## Operation
- Encoding (SEG_ACTIVE_LOW=1): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E (hex); DP clears bit 7; blank = FF.
- Registers: slot counter, width $clog2(REFRESH_DIV); digit index, width $clog2(DIGITS) (min 1); shadow and active copies of value/blank_mask.
- FSM: BLANK (first cycle of each slot: digit_en all off, seg_out blank) -> DRIVE (remaining REFRESH_DIV-1 cycles: digit_en selects index, seg_out = decoded active nibble, or blank if active blank bit set).
- Slot end (counter = REFRESH_DIV-1): counter -> 0, index increments; index DIGITS-1 wraps to 0.
- Frame boundary = slot end with index DIGITS-1: frame_done high that cycle; if pending or load, active <= load ? inputs : shadow; pending clears.
- load: shadow <= value/blank_mask, pending <= 1. Back-to-back loads: last one wins. load coincident with boundary: loaded data applied directly, pending ends 0.
- Display never shows a mix of two loads within a frame (tear-free).

## Timing
- Reset (async assert): counter 0, index 0, shadow/active 0, pending 0, frame_done 0, seg_out blank, digit_en all off, FSM BLANK.
- After reset release: first edge is BLANK cycle of digit 0; digit 0 driven from second edge.
- Output latency: seg_out/digit_en registered, reflect state one cycle after the decision edge.
- Slot = REFRESH_DIV cycles; frame = DIGITS*REFRESH_DIV cycles; load-to-visible latency <= one frame + 1 cycle.
- pending rises the cycle after load, falls the cycle after the applying boundary.
- Reset mid-frame: immediate blank; shadow/pending lost; scan restarts at digit 0.
- dp_mask change appears on the next DRIVE cycle of that digit (no buffering).

## Configuration
- HEX_SCAN_BLINK_EN defined: adds input blink_mask[DIGITS-1:0] (buffered with load like blank_mask) and a blink phase bit toggling every 32 frames; blinking digits are dark while phase = 1. Phase resets to 0.
- Undefined: no blink_mask port, no phase bit; behaviour exactly as above.

## Test plan
Bench uses DIGITS=4, REFRESH_DIV=4.
- Reset held low, then released: seg_out=FF, digit_en=1111 during reset; cycle 2 digit_en=1110, seg_out=C0 (value 0).
- load value=16'h1A2F, blank_mask=0 mid-frame: pending=1; after next frame_done digits 0..3 show 8E, A4, 88, F9; pending=0.
- Two loads in one frame (16'h1111 then 16'h2222): only 2222 (A4 on every digit) ever appears; no 1111.
- load coincident with frame_done: value applied at that boundary, pending never asserted; next frame shows new data.
- blank_mask=4'b1010 with value 16'h8888: digits 1 and 3 show FF with digit_en still pulsing, digits 0 and 2 show 80; dp_mask=0001 makes digit 0 show 00.
- Async reset asserted mid-DRIVE of digit 2: outputs blank within same cycle; after release scan restarts at digit 0, frame_done after 16 cycles.
